// File: rtl/cell_histogram_nxn.sv
// rtl/cell_histogram_nxn.sv - per-cell orientation histogram accumulator with band memory and 2-entry output queue
// Each row segment of a cell is summed, folded into its band entry, and the finished cell is queued for output.

module cell_histogram_nxn #(
    parameter int DATA_WIDTH       = 8,
    parameter int IMAGE_WIDTH      = 640,
    parameter int CELL_SIZE        = 8,
    parameter int NBINS            = 9,
    parameter int SUM_BIN          = 1,
    parameter int OUTPUT_BIN_WIDTH = DATA_WIDTH + 2 * $clog2(CELL_SIZE)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    input  logic                                            in_sof,
    input  logic [DATA_WIDTH-1:0]                           magnitude,
    input  logic [3:0]                                      bin_index,
    output logic                                            in_ready,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [OUTPUT_BIN_WIDTH*(NBINS+SUM_BIN)-1:0]     full_histogram,
    output logic [15:0]                                     cell_x,
    output logic [15:0]                                     cell_y
);

    localparam int CELLS_PER_ROW = IMAGE_WIDTH / CELL_SIZE;
    localparam int HIST_BINS     = NBINS + SUM_BIN;
    localparam int W             = OUTPUT_BIN_WIDTH;
    localparam int HW            = W * HIST_BINS;
    localparam int SXW           = $clog2(CELL_SIZE);
    localparam int CXW           = (CELLS_PER_ROW > 1) ? $clog2(CELLS_PER_ROW) : 1;

    localparam logic [SXW-1:0] SX_LAST = SXW'(CELL_SIZE - 1);
    localparam logic [CXW-1:0] CX_LAST = CXW'(CELLS_PER_ROW - 1);

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    // raster position counters
    logic [SXW-1:0] r_sub_x;
    logic [CXW-1:0] r_cx;
    logic [SXW-1:0] r_sub_y;
    logic [15:0]    r_cy;

    // segment accumulator and registered completed segment
    logic [HW-1:0]  r_seg;
    logic [HW-1:0]  r_seg_done;
    logic           r_seg_valid;
    logic           r_seg_last;
    logic [CXW-1:0] r_seg_cx;
    logic [15:0]    r_seg_cy;

    // band memory: one partial cell per cell column
    logic [HW-1:0]            r_band [CELLS_PER_ROW];
    logic [CELLS_PER_ROW-1:0] r_band_vld;

    // output queue
    logic [HW-1:0] r_fifo_hist [2];
    logic [15:0]   r_fifo_x    [2];
    logic [15:0]   r_fifo_y    [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic           w_accept;
    logic           w_sof;
    logic           w_bin_ok;
    logic [W-1:0]   w_mag_ext;
    logic [SXW-1:0] w_sub_x_e, w_sub_x_n;
    logic [CXW-1:0] w_cx_e, w_cx_n;
    logic [SXW-1:0] w_sub_y_e, w_sub_y_n;
    logic [15:0]    w_cy_e, w_cy_n;
    logic [HW-1:0]  w_seg_base;
    logic [HW-1:0]  w_seg_next;
    logic [HW-1:0]  w_band_rd;
    logic [HW-1:0]  w_band_sum;
    logic           w_push;
    logic           w_pop;

    assign w_accept = in_valid && in_ready;
    assign w_sof    = w_accept && in_sof;
    assign w_bin_ok = int'(bin_index) < NBINS;
    assign w_mag_ext = W'(magnitude);

    // a frame start places the pixel at the origin with an empty segment
    assign w_sub_x_e  = in_sof ? '0 : r_sub_x;
    assign w_cx_e     = in_sof ? '0 : r_cx;
    assign w_sub_y_e  = in_sof ? '0 : r_sub_y;
    assign w_cy_e     = in_sof ? '0 : r_cy;
    assign w_seg_base = in_sof ? '0 : r_seg;

    always_comb begin
        w_sub_x_n = w_sub_x_e + SXW'(1);
        w_cx_n    = w_cx_e;
        w_sub_y_n = w_sub_y_e;
        w_cy_n    = w_cy_e;
        if (w_sub_x_e == SX_LAST) begin
            w_sub_x_n = '0;
            if (w_cx_e == CX_LAST) begin
                w_cx_n = '0;
                if (w_sub_y_e == SX_LAST) begin
                    w_sub_y_n = '0;
                    w_cy_n    = w_cy_e + 16'd1;
                end else begin
                    w_sub_y_n = w_sub_y_e + SXW'(1);
                end
            end else begin
                w_cx_n = w_cx_e + CXW'(1);
            end
        end
    end

    // slot NBINS only exists when the sum bin is enabled; out-of-range bins add nothing anywhere
    always_comb begin
        logic [W-1:0] w_inc;
        w_seg_next = '0;
        for (int k = 0; k < HIST_BINS; k++) begin
            w_inc = '0;
            if (w_bin_ok && (k == NBINS || k == int'(bin_index))) begin
                w_inc = w_mag_ext;
            end
            w_seg_next[k*W +: W] = sat_add(w_seg_base[k*W +: W], w_inc);
        end
    end

    assign w_band_rd = r_band_vld[r_seg_cx] ? r_band[r_seg_cx] : '0;

    always_comb begin
        w_band_sum = '0;
        for (int k = 0; k < HIST_BINS; k++) begin
            w_band_sum[k*W +: W] = sat_add(w_band_rd[k*W +: W], r_seg_done[k*W +: W]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sub_x     <= '0;
            r_cx        <= '0;
            r_sub_y     <= '0;
            r_cy        <= '0;
            r_seg       <= '0;
            r_seg_done  <= '0;
            r_seg_valid <= 1'b0;
            r_seg_last  <= 1'b0;
            r_seg_cx    <= '0;
            r_seg_cy    <= '0;
        end else begin
            r_seg_valid <= 1'b0;
            if (w_accept) begin
                r_sub_x <= w_sub_x_n;
                r_cx    <= w_cx_n;
                r_sub_y <= w_sub_y_n;
                r_cy    <= w_cy_n;
                if (w_sub_x_e == SX_LAST) begin
                    r_seg       <= '0;
                    r_seg_done  <= w_seg_next;
                    r_seg_valid <= 1'b1;
                    r_seg_last  <= (w_sub_y_e == SX_LAST);
                    r_seg_cx    <= w_cx_e;
                    r_seg_cy    <= w_cy_e;
                end else begin
                    r_seg <= w_seg_next;
                end
            end
        end
    end

    // a frame start in the same cycle wins over a partial-band write-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_band_vld <= '0;
        end else if (w_sof) begin
            r_band_vld <= '0;
        end else if (r_seg_valid) begin
            r_band_vld[r_seg_cx] <= !r_seg_last;
        end
    end

    always_ff @(posedge clk) begin
        if (r_seg_valid && !r_seg_last) begin
            r_band[r_seg_cx] <= w_band_sum;
        end
    end

    assign w_push = r_seg_valid && r_seg_last;
    assign w_pop  = (r_count != 2'd0) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo_hist[0] <= '0;
            r_fifo_hist[1] <= '0;
            r_fifo_x[0]    <= '0;
            r_fifo_x[1]    <= '0;
            r_fifo_y[0]    <= '0;
            r_fifo_y[1]    <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_hist[r_wr_ptr] <= w_band_sum;
                r_fifo_x[r_wr_ptr]    <= 16'(r_seg_cx);
                r_fifo_y[r_wr_ptr]    <= r_seg_cy;
                r_wr_ptr              <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // stall one cycle early when a finished cell is already on its way to a half-full queue
    assign in_ready       = !((r_count == 2'd2) || ((r_count == 2'd1) && w_push));
    assign out_valid      = (r_count != 2'd0);
    assign full_histogram = r_fifo_hist[r_rd_ptr];
    assign cell_x         = r_fifo_x[r_rd_ptr];
    assign cell_y         = r_fifo_y[r_rd_ptr];

endmodule

// File: tb/tb_cell_histogram_nxn.sv
// tb/tb_cell_histogram_nxn.sv - scoreboard bench for cell_histogram_nxn at 16-pixel rows, 4x4 cells
// A reference model accumulates whole cells from accepted pixels; a monitor pops and compares outputs.

module tb_cell_histogram_nxn;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  magnitude = '0;
    logic [3:0]  bin_index = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [79:0] full_histogram;
    logic [15:0] cell_x;
    logic [15:0] cell_y;

    cell_histogram_nxn #(
        .DATA_WIDTH(8), .IMAGE_WIDTH(16), .CELL_SIZE(4),
        .NBINS(9), .SUM_BIN(1), .OUTPUT_BIN_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .magnitude(magnitude), .bin_index(bin_index), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .full_histogram(full_histogram),
        .cell_x(cell_x), .cell_y(cell_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] h;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int first_ov = -1;
    int n_out = 0;
    int last_acc = 0;
    int hs_cycle = 0;
    logic [79:0] first_hist;
    logic [15:0] first_x, first_y;
    int acc [4][10];
    int m_sx, m_cx, m_sy, m_cy;
    bit bp_done;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (rst_n && out_valid && first_ov < 0) first_ov = cycle;
        if (rst_n && out_valid && out_ready) begin
            if (n_out == 0) begin
                first_hist = full_histogram;
                first_x = cell_x;
                first_y = cell_y;
            end
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got cell (%0d,%0d) hist=%h, required no output", cell_x, cell_y, full_histogram);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (full_histogram !== e.h || cell_x !== e.x || cell_y !== e.y) begin
                    errors++;
                    $display("FAIL cell_output: got (%0d,%0d) hist=%h, required (%0d,%0d) hist=%h",
                             cell_x, cell_y, full_histogram, e.x, e.y, e.h);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic model_reset();
        for (int c = 0; c < 4; c++) for (int k = 0; k < 10; k++) acc[c][k] = 0;
        m_sx = 0; m_cx = 0; m_sy = 0; m_cy = 0;
    endtask

    task automatic model_accept(input int mag, input int bin, input bit sof);
        exp_t e;
        if (sof) model_reset();
        if (bin < 9) begin
            acc[m_cx][bin] += mag;
            acc[m_cx][9]   += mag;
        end
        if (m_sx == 3 && m_sy == 3) begin
            for (int k = 0; k < 10; k++) begin
                e.h[k*8 +: 8] = (acc[m_cx][k] > 255) ? 8'd255 : 8'(acc[m_cx][k]);
                acc[m_cx][k] = 0;
            end
            e.x = 16'(m_cx);
            e.y = 16'(m_cy);
            exp_q.push_back(e);
        end
        m_sx++;
        if (m_sx == 4) begin
            m_sx = 0; m_cx++;
            if (m_cx == 4) begin
                m_cx = 0; m_sy++;
                if (m_sy == 4) begin m_sy = 0; m_cy++; end
            end
        end
    endtask

    task automatic send_px(input logic [7:0] mag, input logic [3:0] bin, input bit sof);
        int waitc;
        in_valid = 1'b1; magnitude = mag; bin_index = bin; in_sof = sof;
        waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 300) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waitc);
        end else begin
            model_accept(int'(mag), int'(bin), sof);
            last_acc = cycle;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    // pat 0: mag 1, bin px%9 | 1: mag 2, bin 0 | 2: mag 255, bin 5 | 3: random | 4: cell 0 uses bin 12
    task automatic send_frame(input int npix, input int pat, input bit sof_first);
        int px, row, mag, bin;
        for (int i = 0; i < npix; i++) begin
            px = i % 16; row = (i / 16) % 4;
            case (pat)
                0: begin mag = 1; bin = px % 9; end
                1: begin mag = 2; bin = 0; end
                2: begin mag = 255; bin = 5; end
                3: begin mag = $urandom_range(1, 7); bin = $urandom_range(0, 8); end
                default: begin mag = 3; bin = (px < 4 && i < 64) ? 12 : px % 9; end
            endcase
            send_px(8'(mag), 4'(bin), sof_first && i == 0);
            if (i == 51) hs_cycle = last_acc;
            if (row < 0) break;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cells still pending, required 0", exp_q.size());
        end
    endtask

    task automatic start_test();
        n_out = 0;
        first_ov = -1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (full_histogram !== 80'd0) begin errors++; $display("FAIL reset_hist: got %h, required 0", full_histogram); end
        checks++; if (cell_x !== 16'd0) begin errors++; $display("FAIL reset_cell_x: got %0d, required 0", cell_x); end
        checks++; if (cell_y !== 16'd0) begin errors++; $display("FAIL reset_cell_y: got %0d, required 0", cell_y); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        start_test();
        send_frame(64, 0, 1'b1);
        drain();
        checks++;
        if (first_ov - hs_cycle != 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, required 2", first_ov - hs_cycle);
        end
        checks++; if (n_out != 4) begin errors++; $display("FAIL basic_count: got %0d, required 4", n_out); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (first_hist[k*8 +: 8] !== ((k < 4) ? 8'd4 : 8'd0)) begin
                errors++;
                $display("FAIL basic_bin%0d: got %0d, required %0d", k, first_hist[k*8 +: 8], (k < 4) ? 4 : 0);
            end
        end
        checks++; if (first_hist[72 +: 8] !== 8'd16) begin errors++; $display("FAIL basic_sum: got %0d, required 16", first_hist[72 +: 8]); end
        @(posedge clk); #1;
    endtask

    task automatic test_vstride();
        start_test();
        send_frame(128, 1, 1'b1);
        drain();
        checks++; if (n_out != 8) begin errors++; $display("FAIL vstride_count: got %0d, required 8", n_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        start_test();
        send_frame(64, 2, 1'b1);
        drain();
        checks++; if (first_hist[40 +: 8] !== 8'd255) begin errors++; $display("FAIL sat_bin5: got %0d, required 255", first_hist[40 +: 8]); end
        checks++; if (first_hist[72 +: 8] !== 8'd255) begin errors++; $display("FAIL sat_sum: got %0d, required 255", first_hist[72 +: 8]); end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid_bin();
        start_test();
        send_frame(64, 4, 1'b1);
        drain();
        checks++;
        if (first_hist !== 80'd0 || first_x !== 16'd0) begin
            errors++;
            $display("FAIL invalid_bin: got cell %0d hist=%h, required cell 0 hist=0", first_x, first_hist);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [79:0] h0;
        logic [15:0] x0, y0;
        int t;
        start_test();
        out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                send_frame(64, 3, 1'b1);
                bp_done = 1'b1;
            end
        join_none
        t = 0;
        @(negedge clk);
        while (in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_fall: got %b, required 0", in_ready); end
        checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL bp_queued_cells: got %0d, required 2", exp_q.size()); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
        h0 = full_histogram; x0 = cell_x; y0 = cell_y;
        repeat (8) @(negedge clk);
        checks++;
        if (full_histogram !== h0 || cell_x !== x0 || cell_y !== y0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got (%0d,%0d) %h valid=%b, required (%0d,%0d) %h valid=1",
                     cell_x, cell_y, full_histogram, out_valid, x0, y0, h0);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold: got %b, required 0", in_ready); end
        out_ready = 1'b1;
        t = 0;
        while (!bp_done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++; if (!bp_done) begin errors++; $display("FAIL bp_resume: stimulus done=%0b, required 1", bp_done); end
        drain();
        checks++; if (n_out != 4) begin errors++; $display("FAIL bp_count: got %0d, required 4", n_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_resync();
        start_test();
        send_frame(36, 3, 1'b1);
        send_frame(64, 3, 1'b1);
        drain();
        checks++; if (n_out != 4) begin errors++; $display("FAIL resync_count: got %0d, required 4", n_out); end
        checks++;
        if (first_x !== 16'd0 || first_y !== 16'd0) begin
            errors++;
            $display("FAIL resync_first_cell: got (%0d,%0d), required (0,0)", first_x, first_y);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        start_test();
        out_ready = 1'b0;
        send_frame(53, 0, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b, required 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n_out = 0;
        @(posedge clk); #1;
        send_frame(64, 0, 1'b0);
        drain();
        checks++; if (n_out != 4) begin errors++; $display("FAIL rstmid_count: got %0d, required 4", n_out); end
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_vstride();
        test_saturation();
        test_invalid_bin();
        test_backpressure();
        test_resync();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
